// File: rtl/u_multiplier_if.sv
// Operand/result bundle for u_multiplier.
// Optional completion strobe 'done' exists only when UMULT_DONE_EN is defined.
interface u_multiplier_if;
    logic [31:0] in1;
    logic [31:0] in2;
    logic [63:0] out;
`ifdef UMULT_DONE_EN
    logic        done;
`endif

`ifdef UMULT_DONE_EN
    modport master (output in1, output in2, input out, input done);
    modport slave  (input in1, input in2, output out, output done);
`else
    modport master (output in1, output in2, input out);
    modport slave  (input in1, input in2, output out);
`endif
endinterface

// File: rtl/u_multiplier.sv
// Sequential 32x32 unsigned multiplier, one multiplier byte per cycle.
// A 64-bit product is published every 4 cycles, free-running.
// Optional feature macro: UMULT_DONE_EN adds a one-cycle 'done' pulse.
module u_multiplier (
    input  logic           clk,
    input  logic           reset,
    u_multiplier_if.slave  bus
);
    localparam logic [1:0] PH_LOAD  = 2'd0;
    localparam logic [1:0] PH_BYTE1 = 2'd1;
    localparam logic [1:0] PH_BYTE2 = 2'd2;
    localparam logic [1:0] PH_BYTE3 = 2'd3;

    logic [1:0]  r_phase;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic [63:0] r_acc;
    logic [63:0] r_out;

    logic [7:0]  w_b_lane [0:3];
    logic [31:0] w_mcand;
    logic [7:0]  w_byte;
    logic [39:0] w_pp;
    logic [63:0] w_pp_shifted;
    logic [63:0] w_acc_base;
    logic [63:0] w_sum;
    logic        w_last;

    // Split the held multiplier into its byte lanes.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign w_b_lane[gi] = r_b[8*gi +: 8];
        end
    endgenerate

    // On the load edge the fresh operands feed the datapath directly so the
    // first partial product is accumulated in the same cycle they are sampled.
    always_comb begin
        w_mcand    = r_a;
        w_byte     = w_b_lane[r_phase];
        w_acc_base = r_acc;
        if (r_phase == PH_LOAD) begin
            w_mcand    = bus.in1;
            w_byte     = bus.in2[7:0];
            w_acc_base = 64'd0;
        end
    end

    // 32x8 partial product, zero-extended and aligned to its byte lane.
    always_comb begin
        w_pp         = {8'd0, w_mcand} * {32'd0, w_byte};
        w_pp_shifted = {24'd0, w_pp} << {r_phase, 3'b000};
        w_sum        = w_acc_base + w_pp_shifted;
        w_last       = (r_phase == PH_BYTE3);
    end

    // Phase counter, operand capture, accumulation and result publication.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_phase <= PH_LOAD;
            r_a     <= 32'd0;
            r_b     <= 32'd0;
            r_acc   <= 64'd0;
            r_out   <= 64'd0;
        end else begin
            r_phase <= r_phase + 2'd1;
            r_acc   <= w_sum;
            if (r_phase == PH_LOAD) begin
                r_a <= bus.in1;
                r_b <= bus.in2;
            end
            if (w_last) begin
                r_out <= w_sum;
            end
        end
    end

    assign bus.out = r_out;

`ifdef UMULT_DONE_EN
    logic r_done;

    // Completion strobe: high for the single cycle after the final byte edge.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_done <= 1'b0;
        end else begin
            r_done <= w_last;
        end
    end

    assign bus.done = r_done;
`else
    // Byte lanes 1..2 named so phase constants document the sequence.
    logic w_unused_phase_names;
    assign w_unused_phase_names = (PH_BYTE1 == PH_BYTE2);
`endif
endmodule

// File: tb/tb_u_multiplier.sv
// Self-checking bench for u_multiplier: table vectors, hand sequences and
// random operands checked against a plain 64-bit multiply.
module tb_u_multiplier;
    logic clk;
    logic reset;

    u_multiplier_if bus_if ();

    u_multiplier dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total;
    int bad;
    int op_num;
    logic [63:0] prev_out;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] exp;
    } vec_t;

    vec_t vecs [0:6];

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, got, want);
        end
    endtask

    task automatic chk_done(input string nm, input logic want);
`ifdef UMULT_DONE_EN
        chk(nm, {63'd0, bus_if.done}, {63'd0, want});
`else
        if (want === 1'bx) $display("unreachable");
`endif
    endtask

    // Assumes the next rising edge is a load edge. Inputs are scrambled
    // after the load edge to prove operands are held internally.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [63:0] exp);
        bus_if.in1 = a;
        bus_if.in2 = b;
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk);
            #1;
            if (k < 4) begin
                chk("hold_out", bus_if.out, prev_out);
                chk_done("done_low", 1'b0);
                bus_if.in1 = $urandom;
                bus_if.in2 = $urandom;
            end else begin
                chk("product", bus_if.out, exp);
                chk_done("done_pulse", 1'b1);
            end
        end
        prev_out = exp;
        op_num++;
        $display("op %0d: %h x %h -> out %h (want %h)", op_num, a, b, bus_if.out, exp);
    endtask

    task automatic do_reset(input int edges);
        reset = 1'b0;
        for (int i = 0; i < edges; i++) begin
            @(posedge clk);
            #1;
            chk("rst_out", bus_if.out, 64'd0);
            chk_done("rst_done", 1'b0);
        end
        reset = 1'b1;
        prev_out = 64'd0;
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        total  = 0;
        bad    = 0;
        op_num = 0;
        prev_out = 64'd0;
        reset = 1'b1;
        bus_if.in1 = 32'd0;
        bus_if.in2 = 32'd0;

        vecs[0] = '{32'd3,          32'd5,          64'h0000_0000_0000_000F};
        vecs[1] = '{32'hFFFF_FFFF,  32'hFFFF_FFFF,  64'hFFFF_FFFE_0000_0001};
        vecs[2] = '{32'd7,          32'd9,          64'h0000_0000_0000_003F};
        vecs[3] = '{32'd6,          32'd7,          64'h0000_0000_0000_002A};
        vecs[4] = '{32'd1,          32'h0102_0304,  64'h0000_0000_0102_0304};
        vecs[5] = '{32'h0001_0000,  32'hFF00_0000,  64'h0000_FF00_0000_0000};
        vecs[6] = '{32'h8000_0000,  32'd2,          64'h0000_0001_0000_0000};

        @(negedge clk);
        do_reset(3);

        // Table vectors, back-to-back with no bubble.
        for (int i = 0; i < 7; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].exp);
        end

        // Basic product right after a single-edge reset.
        do_reset(1);
        run_op(32'd3, 32'd5, 64'h0F);
        // Back-to-back follow-on 6x7.
        run_op(32'd6, 32'd7, 64'd42);

        // Reset mid-operation discards the partial result.
        bus_if.in1 = 32'h8000_0000;
        bus_if.in2 = 32'd2;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        do_reset(1);
        run_op(32'h8000_0000, 32'd2, 64'h0000_0001_0000_0000);

        // A reset glitch entirely between edges has no effect.
        bus_if.in1 = 32'd11;
        bus_if.in2 = 32'd13;
        @(posedge clk);
        #2;
        reset = 1'b0;
        #2;
        reset = 1'b1;
        for (int k = 2; k <= 4; k++) begin
            @(posedge clk);
            #1;
        end
        chk("glitch_product", bus_if.out, 64'd143);
        prev_out = 64'd143;

        // Random operands against an arithmetic reference.
        for (int i = 0; i < 24; i++) begin
            ra = $urandom;
            rb = $urandom;
            if (i == 0) ra = 32'd0;
            if (i == 1) rb = 32'hFFFF_FFFF;
            run_op(ra, rb, {32'd0, ra} * {32'd0, rb});
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
